// File: rtl/reg_bank_arbiter_pkg.sv
// Shared constants, client identifiers and helpers for reg_bank_arbiter.
package reg_bank_arbiter_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned AW_DEF    = 3;

  typedef enum logic {
    CLIENT0 = 1'b0,
    CLIENT1 = 1'b1
  } client_t;

  // Saturating 16-bit increment used by the grant counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_arbiter2.sv
// Two-client round-robin arbiter: one-hot grant and next priority, purely combinational.
module rr_arbiter2
  import reg_bank_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  client_t    prio,
  output logic [1:0] grant,
  output client_t    prio_next
);

  // Tie goes to prio; after any grant the other client gets priority.
  always_comb begin
    grant     = '0;
    prio_next = prio;
    if (req0 && req1) begin
      grant = (prio == CLIENT0) ? 2'b01 : 2'b10;
    end else begin
      grant = {req1, req0};
    end
    if (grant[0]) begin
      prio_next = CLIENT1;
    end else if (grant[1]) begin
      prio_next = CLIENT0;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by two clients through a round-robin arbiter.
// Optional feature macro: ARB_STATS_EN adds saturating per-client grant counters cnt0/cnt1.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] din0,
  output logic             gnt0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  logic [WIDTH-1:0] bank [DEPTH];
  client_t          prio;
  client_t          prio_next;
  logic [1:0]       grant;

  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_din;

  rr_arbiter2 u_arb (
    .req0      (req0),
    .req1      (req1),
    .prio      (prio),
    .grant     (grant),
    .prio_next (prio_next)
  );

  // Steer the winning client's access fields to the bank port.
  always_comb begin
    sel_we   = we0;
    sel_addr = addr0;
    sel_din  = din0;
    if (grant[1]) begin
      sel_we   = we1;
      sel_addr = addr1;
      sel_din  = din1;
    end
  end

  // Arbitration state, grant pulses and the bank access of the winner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio  <= CLIENT0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      rdata <= '0;
      busy  <= 1'b0;
      bank  <= '{default: '0};
    end else begin
      prio <= prio_next;
      gnt0 <= grant[0];
      gnt1 <= grant[1];
      busy <= req0 & req1;
      if (|grant) begin
        if (sel_we) begin
          bank[sel_addr] <= sel_din;
        end else begin
          rdata <= bank[sel_addr];
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  // Per-client grant counters, saturating at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (grant[0]) cnt0 <= sat_inc16(cnt0);
      if (grant[1]) cnt1 <= sat_inc16(cnt1);
    end
  end
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter against a transaction-level model.
module tb_reg_bank_arbiter;

  localparam int W = 16;
  localparam int D = 8;
  localparam int A = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [A-1:0] addr0 = '0, addr1 = '0;
  logic [W-1:0] din0 = '0, din1 = '0;
  logic         gnt0, gnt1, busy;
  logic [W-1:0] rdata;
`ifdef ARB_STATS_EN
  logic [15:0]  cnt0, cnt1;
`endif

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [W-1:0] mbank [D];
  int           mprio;
  logic         e_g0, e_g1, e_busy;
  logic [W-1:0] e_rdata;
  int           m_cnt0, m_cnt1;

  reg_bank_arbiter #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
    .clock (clock), .reset (reset),
    .req0  (req0),  .we0 (we0), .addr0 (addr0), .din0 (din0), .gnt0 (gnt0),
    .req1  (req1),  .we1 (we1), .addr1 (addr1), .din1 (din1), .gnt1 (gnt1),
    .rdata (rdata), .busy (busy)
`ifdef ARB_STATS_EN
    , .cnt0 (cnt0), .cnt1 (cnt1)
`endif
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < D; i++) mbank[i] = '0;
    mprio = 0; e_g0 = 0; e_g1 = 0; e_busy = 0; e_rdata = '0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  task automatic clear_inputs();
    req0 = 0; we0 = 0; addr0 = '0; din0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; din1 = '0;
  endtask

  // Apply the arbitration rules to the current requests, then advance one edge.
  task automatic cycle();
    int w;
    w = -1;
    if (req0 && req1) w = mprio;
    else if (req0)    w = 0;
    else if (req1)    w = 1;
    e_busy = req0 && req1;
    e_g0 = (w == 0);
    e_g1 = (w == 1);
    if (w == 0) begin
      if (we0) mbank[addr0] = din0; else e_rdata = mbank[addr0];
      mprio = 1;
      if (m_cnt0 < 65535) m_cnt0++;
    end else if (w == 1) begin
      if (we1) mbank[addr1] = din1; else e_rdata = mbank[addr1];
      mprio = 0;
      if (m_cnt1 < 65535) m_cnt1++;
    end
    @(posedge clock); #1;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset = 1; #1;
    model_reset();
    @(negedge clock);
    reset = 0;
    cycle();
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++;
    if ({gnt0, gnt1, busy, rdata} !== {3'b000, 16'h0000})
      $display("FAIL reset_state: got g0=%b g1=%b busy=%b rdata=%h want all 0", gnt0, gnt1, busy, rdata);
    else passes++;
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; addr0 = 3; din0 = 16'd10;
    cycle();
    checks++;
    if ({gnt0, gnt1} !== 2'b10)
      $display("FAIL write_grant: got g0=%b g1=%b want 1 0", gnt0, gnt1);
    else passes++;
    we0 = 0;
    cycle();
    checks++;
    if ({gnt0, gnt1, rdata} !== {2'b10, 16'd10})
      $display("FAIL read_back: got g0=%b g1=%b rdata=%0d want 1 0 10", gnt0, gnt1, rdata);
    else passes++;
    clear_inputs();
    cycle();
    checks++;
    if ({gnt0, gnt1, rdata} !== {2'b00, 16'd10})
      $display("FAIL rdata_hold: got g0=%b g1=%b rdata=%0d want 0 0 10", gnt0, gnt1, rdata);
    else passes++;
  endtask

  task automatic test_tie();
    pulse_reset();
    req0 = 1; req1 = 1; addr0 = 1; addr1 = 2;
    cycle();
    checks++;
    if ({gnt0, gnt1, busy} !== 3'b101)
      $display("FAIL tie_first: got g0=%b g1=%b busy=%b want 1 0 1", gnt0, gnt1, busy);
    else passes++;
    req0 = 0;
    cycle();
    checks++;
    if ({gnt0, gnt1, busy} !== 3'b010)
      $display("FAIL tie_second: got g0=%b g1=%b busy=%b want 0 1 0", gnt0, gnt1, busy);
    else passes++;
    clear_inputs();
    cycle();
  endtask

  task automatic test_alternate();
    logic [5:0] seq;
    pulse_reset();
    seq = '0;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (gnt0 === gnt1) $display("FAIL alt_onehot: cycle %0d got g0=%b g1=%b", i, gnt0, gnt1);
      else passes++;
      seq[i] = gnt1;
    end
    checks++;
    if (seq !== 6'b101010) $display("FAIL alt_sequence: got %b want 101010 (bit i = gnt1 at cycle i)", seq);
    else passes++;
    clear_inputs();
    cycle();
  endtask

  task automatic test_raw();
    req0 = 1; we0 = 1; addr0 = 5; din0 = 16'd100;
    cycle();
    clear_inputs();
    req1 = 1; we1 = 0; addr1 = 5;
    cycle();
    checks++;
    if ({gnt0, gnt1, rdata} !== {2'b01, 16'd100})
      $display("FAIL raw_client1: got g0=%b g1=%b rdata=%0d want 0 1 100", gnt0, gnt1, rdata);
    else passes++;
    clear_inputs();
    cycle();
  endtask

  task automatic test_random();
    logic p0, p1;
    p0 = 0; p1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 9) < 5) begin
        p0 = 1; req0 = 1; we0 = $urandom_range(0, 1); addr0 = $urandom; din0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 9) < 5) begin
        p1 = 1; req1 = 1; we1 = $urandom_range(0, 1); addr1 = $urandom; din1 = $urandom;
      end
      cycle();
      checks++;
      if ({gnt0, gnt1, busy, rdata} !== {e_g0, e_g1, e_busy, e_rdata})
        $display("FAIL random_cycle %0d: got g0=%b g1=%b busy=%b rdata=%h want %b %b %b %h",
                 i, gnt0, gnt1, busy, rdata, e_g0, e_g1, e_busy, e_rdata);
      else passes++;
      if (e_g0) begin p0 = 0; req0 = 0; end
      if (e_g1) begin p1 = 0; req1 = 0; end
    end
    clear_inputs();
    cycle();
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < D; a++) begin
      req0 = 1; we0 = 1; addr0 = a; din0 = 16'hA5A0 + 16'(a);
      cycle();
    end
    req0 = 1; we0 = 0; addr0 = 4;
    cycle();
    req0 = 1; we0 = 1; addr0 = 2; din0 = 16'hBEEF;
    #2 reset = 1; #1;
    checks++;
    if ({gnt0, gnt1, busy, rdata} !== {3'b000, 16'h0000})
      $display("FAIL reset_async: got g0=%b g1=%b busy=%b rdata=%h want all 0", gnt0, gnt1, busy, rdata);
    else passes++;
    model_reset();
    @(posedge clock); #1;
    checks++;
    if ({gnt0, gnt1} !== 2'b00)
      $display("FAIL reset_abort: got g0=%b g1=%b want 0 0", gnt0, gnt1);
    else passes++;
    @(negedge clock);
    reset = 0;
    clear_inputs();
    cycle();
    for (int a = 0; a < D; a++) begin
      req0 = 1; we0 = 0; addr0 = a;
      cycle();
      checks++;
      if ({gnt0, rdata} !== {1'b1, 16'h0000})
        $display("FAIL reset_word %0d: got g0=%b rdata=%h want 1 0000", a, gnt0, rdata);
      else passes++;
    end
    clear_inputs();
    cycle();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin req0 = 1; cycle(); req0 = 0; cycle(); end
    for (int i = 0; i < 2; i++) begin req1 = 1; cycle(); req1 = 0; cycle(); end
    checks++;
    if ({cnt0, cnt1} !== {16'd3, 16'd2})
      $display("FAIL stats_count: got cnt0=%0d cnt1=%0d want 3 2", cnt0, cnt1);
    else passes++;
    req0 = 1;
    for (int i = 0; i < 65540; i++) cycle();
    clear_inputs();
    cycle();
    checks++;
    if ({cnt0, cnt1} !== {16'(m_cnt0), 16'(m_cnt1)} || cnt0 !== 16'hFFFF)
      $display("FAIL stats_saturate: got cnt0=%h cnt1=%h want ffff %h", cnt0, cnt1, 16'(m_cnt1));
    else passes++;
  endtask
`endif

  initial begin
    model_reset();
    clear_inputs();
    reset = 1;
    #12;
    test_reset();
    test_write_read();
    test_tie();
    test_alternate();
    test_raw();
    test_random();
    test_reset_mid();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
